// File: rtl/shift_seq_if.sv
// Command-side bus of the shift-register sequencer.
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the sequencer is idle.
// A requester may hold cmd_valid high for as long as it likes. Commands offered
// while cmd_ready is low are not stored, and nothing is queued.
interface shift_seq_if #(
  parameter int W  = 8,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_amt;
  logic [W-1:0]  cmd_data;
  logic          cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq.sv
// Sequencer for an external W-bit universal shift register with mode pins {l,r}:
// 00 hold, 01 up, 10 down, 11 parallel load.
// One command is taken per handshake. The sequencer drives the mode, data and
// serial pins for as many cycles as the command needs. It then captures q into
// res and pulses done.
// The current FSM state is exported on state_dbg.
module shift_seq #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic           c,
  input  logic           nrst,
  shift_seq_if.slave     cmd,
  output logic           sh_l,
  output logic           sh_r,
  output logic [W-1:0]   sh_d,
  output logic           sh_i,
  input  logic [W-1:0]   sh_q,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   res,
  output logic           res_valid,
  output logic [1:0]     state_dbg
);

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHU  = 3'b010;
  localparam logic [2:0] OP_SHD  = 3'b011;
  localparam logic [2:0] OP_ROTU = 3'b100;
  localparam logic [2:0] OP_ROTD = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          fill_q;
  logic          ready;

  assign ready         = (state == S_IDLE);
  assign cmd.cmd_ready = ready;
  assign busy          = ~ready;
  assign state_dbg     = state;

  // Control FSM. The mode and data pins are registered, so they are set on the edge that enters each state.
  always_ff @(posedge c or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      sh_l      <= 1'b0;
      sh_r      <= 1'b0;
      sh_d      <= '0;
      cnt       <= '0;
      op_q      <= 3'b000;
      fill_q    <= 1'b0;
      done      <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q      <= cmd.cmd_op;
            fill_q    <= cmd.cmd_fill;
            res_valid <= 1'b0;
            case (cmd.cmd_op)
              OP_LOAD, OP_CLR: begin
                state <= S_LOAD;
                sh_l  <= 1'b1;
                sh_r  <= 1'b1;
                sh_d  <= (cmd.cmd_op == OP_CLR) ? '0 : cmd.cmd_data;
              end
              OP_SHU, OP_ROTU: begin
                if (cmd.cmd_amt != '0) begin
                  state <= S_SHIFT;
                  cnt   <= cmd.cmd_amt;
                  sh_r  <= 1'b1;
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end
              OP_SHD, OP_ROTD: begin
                if (cmd.cmd_amt != '0) begin
                  state <= S_SHIFT;
                  cnt   <= cmd.cmd_amt;
                  sh_l  <= 1'b1;
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          state <= S_DONE;
          sh_l  <= 1'b0;
          sh_r  <= 1'b0;
          sh_d  <= '0;
          done  <= 1'b1;
        end
        S_SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            sh_l  <= 1'b0;
            sh_r  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          res       <= sh_q;
          res_valid <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          sh_l  <= 1'b0;
          sh_r  <= 1'b0;
          sh_d  <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The serial input is driven only while shifting. Rotates feed back the bit that is leaving the register.
  always_comb begin
    sh_i = 1'b0;
    if (state == S_SHIFT) begin
      case (op_q)
        OP_ROTU: sh_i = sh_q[W-1];
        OP_ROTD: sh_i = sh_q[0];
        default: sh_i = fill_q;
      endcase
    end
  end

endmodule
